// File: rtl/hack_pkg.sv
// Shared constants for the Hack CPU fetch/sequencing blocks: state encoding and
// jump-field layout of C-instructions.
package hack_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } fetch_state_t;

  localparam int J_LSB     = 0;
  localparam int J_MSB     = 2;
  localparam int CINST_BIT = 15;

  localparam logic [2:0] JMP_ALWAYS = 3'b111;

endpackage

// File: rtl/hack_jump_cond.sv
// Hack jump rule: decides whether a C-instruction jumps given the ALU zero and
// negative flags. Purely combinational; A-instructions never jump.
module hack_jump_cond
  import hack_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] i_instr,
  input  logic          i_zr,
  input  logic          i_ng,
  output logic          o_take
);

  logic [2:0] w_j;
  logic       w_unused_instr;

  assign w_j            = i_instr[J_MSB:J_LSB];
  assign w_unused_instr = ^i_instr;

  // j1 = instr[2] (negative), j2 = instr[1] (zero), j3 = instr[0] (positive)
  assign o_take = i_instr[CINST_BIT] &
                  ((w_j[2] & i_ng) | (w_j[1] & i_zr) | (w_j[0] & ~i_ng & ~i_zr));

endmodule

// File: rtl/hack_fetch_ctrl.sv
// Hack CPU fetch / PC sequencer: INIT -> FETCH -> EXEC -> UPDATE loop driving the pc strobes.
// Optional tight-loop halt detection is compiled in with HACK_FETCH_HALT_DETECT_EN.
module hack_fetch_ctrl
  import hack_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          exec_done,
  input  logic          alu_zr,
  input  logic          alu_ng,
  input  logic [DW-1:0] a_reg,
  input  logic [DW-1:0] pc_out,
  output logic [DW-1:0] pc_in,
  output logic          pc_load,
  output logic          pc_inc,
  output logic          pc_reset,
  output logic          halted
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  logic          r_imem_req;
  logic [DW-1:0] r_instr;
  logic          r_instr_valid;
  logic          r_pc_load;
  logic          r_pc_inc;
  logic          r_pc_reset;

  logic          w_req_next;
  logic [DW-1:0] w_instr_next;
  logic          w_valid_next;
  logic          w_load_next;
  logic          w_inc_next;
  logic          w_pc_reset_next;
  logic          w_take;
  logic          w_unused_pc_hi;

`ifdef HACK_FETCH_HALT_DETECT_EN
  logic r_halted;
  logic w_halted_next;
  logic w_halt_hit;

  // Unconditional jump to its own address: the program can never leave this loop.
  assign w_halt_hit = r_instr[CINST_BIT] &&
                      (r_instr[J_MSB:J_LSB] == JMP_ALWAYS) &&
                      (a_reg[AW-1:0] == pc_out[AW-1:0]);
`endif

  hack_jump_cond #(
    .DW(DW)
  ) u_jump_cond (
    .i_instr (r_instr),
    .i_zr    (alu_zr),
    .i_ng    (alu_ng),
    .o_take  (w_take)
  );

  // Next-state and next-output decode; outputs are registered against the state they belong to.
  always_comb begin
    w_state_next    = r_state;
    w_req_next      = 1'b0;
    w_instr_next    = r_instr;
    w_valid_next    = 1'b0;
    w_load_next     = 1'b0;
    w_inc_next      = 1'b0;
    w_pc_reset_next = 1'b0;
`ifdef HACK_FETCH_HALT_DETECT_EN
    w_halted_next   = 1'b0;
`endif
    case (r_state)
      ST_INIT: begin
        // First cycle raises pc_reset, second cycle (pc_reset high) moves on.
        if (r_pc_reset) begin
          w_state_next = ST_FETCH;
          w_req_next   = ~stall;
        end else begin
          w_pc_reset_next = 1'b1;
        end
      end
      ST_FETCH: begin
        if (r_imem_req) begin
          if (imem_ack) begin
            w_state_next = ST_EXEC;
            w_instr_next = imem_rdata;
            w_valid_next = 1'b1;
          end else begin
            w_req_next = 1'b1;
          end
        end else begin
          w_req_next = ~stall;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          w_state_next = ST_UPDATE;
          w_load_next  = w_take;
          w_inc_next   = ~w_take;
        end else begin
          w_valid_next = 1'b1;
        end
      end
      ST_UPDATE: begin
`ifdef HACK_FETCH_HALT_DETECT_EN
        if (w_halt_hit) begin
          w_state_next  = ST_HALT;
          w_halted_next = 1'b1;
        end else begin
          w_state_next = ST_FETCH;
          w_req_next   = ~stall;
        end
`else
        w_state_next = ST_FETCH;
        w_req_next   = ~stall;
`endif
      end
`ifdef HACK_FETCH_HALT_DETECT_EN
      ST_HALT: begin
        w_halted_next = 1'b1;
      end
`endif
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // State and registered output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_INIT;
      r_imem_req    <= 1'b0;
      r_instr       <= {DW{1'b0}};
      r_instr_valid <= 1'b0;
      r_pc_load     <= 1'b0;
      r_pc_inc      <= 1'b0;
      r_pc_reset    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_imem_req    <= w_req_next;
      r_instr       <= w_instr_next;
      r_instr_valid <= w_valid_next;
      r_pc_load     <= w_load_next;
      r_pc_inc      <= w_inc_next;
      r_pc_reset    <= w_pc_reset_next;
    end
  end

`ifdef HACK_FETCH_HALT_DETECT_EN
  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= w_halted_next;
    end
  end

  assign halted = r_halted;
`else
  assign halted = 1'b0;
`endif

  // Address and load value pass through but read as zero whenever the matching strobe is idle.
  assign imem_req       = r_imem_req;
  assign imem_addr      = r_imem_req ? pc_out[AW-1:0] : {AW{1'b0}};
  assign pc_in          = r_pc_load ? a_reg : {DW{1'b0}};
  assign instr          = r_instr;
  assign instr_valid    = r_instr_valid;
  assign pc_load        = r_pc_load;
  assign pc_inc         = r_pc_inc;
  assign pc_reset       = r_pc_reset;
  assign w_unused_pc_hi = ^pc_out;

endmodule
